// File: rtl/instr_fetch_queue.sv
// instr_fetch_queue
//   Decoupled instruction fetch stage. Walks a sequential fetch PC, issues
//   one request at a time to a variable-latency instruction memory over a
//   req/ack handshake, and buffers returned {pc, inst} pairs in a DEPTH-entry
//   FIFO that decode drains through a valid/ready handshake. A redirect
//   flushes the FIFO and restarts fetch at redirect_pc. A request that is
//   still outstanding when the redirect arrives is never abandoned; its data
//   is discarded when it is eventually acknowledged.
//
// Ports
//   clk          clock, rising edge
//   rst          asynchronous reset, active low
//   mem_req      fetch request (registered, held until mem_ack)
//   mem_addr     fetch address (registered, held with mem_req)
//   mem_ack      memory accepts the request and returns mem_rdata this cycle
//   mem_rdata    returned instruction word
//   redirect     one-cycle pulse: flush and restart at redirect_pc
//   redirect_pc  new fetch address
//   inst_valid   FIFO head valid
//   inst         head instruction
//   inst_pc      PC of head instruction
//   inst_ready   decode consumes the head when inst_valid & inst_ready
module instr_fetch_queue #(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    INST_WIDTH = 32,
  parameter int                    DEPTH      = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  mem_req,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic                  mem_ack,
  input  logic [INST_WIDTH-1:0] mem_rdata,
  input  logic                  redirect,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic                  inst_valid,
  output logic [INST_WIDTH-1:0] inst,
  output logic [ADDR_WIDTH-1:0] inst_pc,
  input  logic                  inst_ready
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  // mem_req_reg doubles as the in-flight flag: a request is outstanding
  // exactly while mem_req is high.
  logic                  mem_req_reg,  mem_req_next;
  logic [ADDR_WIDTH-1:0] mem_addr_reg, mem_addr_next;
  logic [ADDR_WIDTH-1:0] fetch_pc_reg, fetch_pc_next;
  logic [CNT_W-1:0]      count_reg,    count_next;
  logic [PTR_W-1:0]      rd_ptr_reg,   rd_ptr_next;
  logic [PTR_W-1:0]      wr_ptr_reg,   wr_ptr_next;
  logic                  drop_reg,     drop_next;

  logic [ADDR_WIDTH-1:0] pc_mem   [DEPTH];
  logic [INST_WIDTH-1:0] inst_mem [DEPTH];

  logic accept;  // handshake completes this cycle
  logic hold;    // request outstanding and not acked: must keep holding it
  logic push;
  logic pop;

  always_comb begin
    accept = mem_req_reg & mem_ack;
    hold   = mem_req_reg & ~mem_ack;
    // Redirect wins over both FIFO operations.
    push   = accept & ~drop_reg & ~redirect;
    pop    = (count_reg != '0) & inst_ready & ~redirect;

    count_next  = count_reg + CNT_W'(push) - CNT_W'(pop);
    rd_ptr_next = rd_ptr_reg + PTR_W'(pop);
    wr_ptr_next = wr_ptr_reg + PTR_W'(push);
    if (redirect) begin
      count_next  = '0;
      rd_ptr_next = '0;
      wr_ptr_next = '0;
    end

    // A dropped ack belongs to the pre-redirect stream, so it must not
    // advance the PC that already points at the redirect target.
    fetch_pc_next = fetch_pc_reg;
    if (redirect)
      fetch_pc_next = redirect_pc;
    else if (accept & ~drop_reg)
      fetch_pc_next = fetch_pc_reg + ADDR_WIDTH'(4);

    // Only an un-acked outstanding request needs its data dropped later.
    if (redirect)
      drop_next = hold;
    else
      drop_next = drop_reg & ~accept;

    // A new request reserves a FIFO slot, so it is raised only when the
    // post-update occupancy leaves room for its data.
    mem_req_next  = hold | (count_next < CNT_W'(DEPTH));
    mem_addr_next = hold ? mem_addr_reg : fetch_pc_next;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_req_reg  <= 1'b0;
      mem_addr_reg <= RESET_PC;
      fetch_pc_reg <= RESET_PC;
      count_reg    <= '0;
      rd_ptr_reg   <= '0;
      wr_ptr_reg   <= '0;
      drop_reg     <= 1'b0;
    end else begin
      mem_req_reg  <= mem_req_next;
      mem_addr_reg <= mem_addr_next;
      fetch_pc_reg <= fetch_pc_next;
      count_reg    <= count_next;
      rd_ptr_reg   <= rd_ptr_next;
      wr_ptr_reg   <= wr_ptr_next;
      drop_reg     <= drop_next;
    end
  end

  // FIFO storage, one register pair per entry. Entries are reset so the
  // head outputs read as zero out of reset.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      logic [ADDR_WIDTH-1:0] pc_reg;
      logic [INST_WIDTH-1:0] inst_reg;

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          pc_reg   <= '0;
          inst_reg <= '0;
        end else if (push && (wr_ptr_reg == PTR_W'(gi))) begin
          pc_reg   <= mem_addr_reg;
          inst_reg <= mem_rdata;
        end
      end

      assign pc_mem[gi]   = pc_reg;
      assign inst_mem[gi] = inst_reg;
    end
  endgenerate

  assign mem_req    = mem_req_reg;
  assign mem_addr   = mem_addr_reg;
  assign inst_valid = (count_reg != '0);
  assign inst       = inst_mem[rd_ptr_reg];
  assign inst_pc    = pc_mem[rd_ptr_reg];

endmodule

// File: tb/tb_instr_fetch_queue.sv
// tb_instr_fetch_queue
//   Randomized bench for instr_fetch_queue. A behavioural memory acks with
//   a selectable latency, decode readiness and redirects are randomized, and
//   a transaction-level model (a queue of expected {pc, inst} entries plus
//   the expected next fetch address) predicts what decode must see.
module tb_instr_fetch_queue;

  localparam int          AW    = 32;
  localparam int          IW    = 32;
  localparam int          DEPTH = 4;
  localparam logic [31:0] RPC   = 32'h0000_0000;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          mem_req;
  logic [AW-1:0] mem_addr;
  logic          mem_ack = 1'b0;
  logic [IW-1:0] mem_rdata = '0;
  logic          redirect = 1'b0;
  logic [AW-1:0] redirect_pc = '0;
  logic          inst_valid;
  logic [IW-1:0] inst;
  logic [AW-1:0] inst_pc;
  logic          inst_ready = 1'b0;

  instr_fetch_queue #(
    .ADDR_WIDTH(AW),
    .INST_WIDTH(IW),
    .DEPTH     (DEPTH),
    .RESET_PC  (RPC)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_ack    (mem_ack),
    .mem_rdata  (mem_rdata),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .inst_valid (inst_valid),
    .inst       (inst),
    .inst_pc    (inst_pc),
    .inst_ready (inst_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } entry_t;

  // Reference model state
  entry_t      model_q[$];
  logic [31:0] exp_pc;
  bit          stale;       // outstanding request belongs to a flushed stream
  bit          prev_hold;   // last cycle had an un-acked request
  logic [31:0] prev_addr;

  // Memory model state
  bit          mem_busy;
  int          wait_cnt;

  // Stimulus controls
  int          lat_mode;    // 0: zero-wait, 1: 3-cycle ack, 2: random 0..3 waits
  int          ready_mode;  // 0: always ready, 1: never ready, 2: random
  int          redir_pct;
  bit          force_redir;
  logic [31:0] force_pc;

  int n_checks = 0;
  int n_fail   = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h5A5A_0000;
  endfunction

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    model_q.delete();
    exp_pc    = RPC;
    stale     = 1'b0;
    prev_hold = 1'b0;
    prev_addr = RPC;
    mem_busy  = 1'b0;
    wait_cnt  = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst        = 1'b0;
    mem_ack    = 1'b0;
    redirect   = 1'b0;
    inst_ready = 1'b0;
    #1;
    check_val("rst_mem_req",    mem_req,    1'b0);
    check_val("rst_mem_addr",   mem_addr,   RPC);
    check_val("rst_inst_valid", inst_valid, 1'b0);
    check_val("rst_inst",       inst,       32'h0);
    check_val("rst_inst_pc",    inst_pc,    32'h0);
    model_reset();
    @(negedge clk);
    check_val("rst_hold_mem_req", mem_req, 1'b0);
    rst = 1'b1;
  endtask

  function automatic int pick_lat();
    case (lat_mode)
      0:       return 0;
      1:       return 2;
      default: return int'($urandom_range(0, 3));
    endcase
  endfunction

  // One clock cycle: check outputs, drive inputs, advance the model as the
  // coming rising edge will.
  task automatic step();
    bit   accepted;
    entry_t e;
    @(negedge clk);

    check_val("inst_valid", inst_valid, model_q.size() != 0);
    if (model_q.size() != 0) begin
      check_val("inst_pc", inst_pc, model_q[0].pc);
      check_val("inst",    inst,    model_q[0].inst);
    end
    if (prev_hold) begin
      check_val("req_hold",  mem_req,  1'b1);
      check_val("addr_hold", mem_addr, prev_addr);
    end else begin
      check_val("req_issue", mem_req, model_q.size() < DEPTH);
    end
    if (mem_req && !stale)
      check_val("mem_addr", mem_addr, exp_pc);

    // Memory
    if (mem_req && !mem_busy) begin
      mem_busy = 1'b1;
      wait_cnt = pick_lat();
    end
    if (mem_busy) begin
      if (wait_cnt == 0) begin
        mem_ack   = 1'b1;
        mem_rdata = mem_word(mem_addr);
      end else begin
        wait_cnt--;
        mem_ack   = 1'b0;
        mem_rdata = $urandom;
      end
    end else begin
      // Stray ack with no request pending must be ignored.
      mem_ack   = ($urandom_range(0, 7) == 0);
      mem_rdata = $urandom;
    end

    case (ready_mode)
      0:       inst_ready = 1'b1;
      1:       inst_ready = 1'b0;
      default: inst_ready = ($urandom_range(0, 3) != 0);
    endcase

    redirect = 1'b0;
    if (force_redir) begin
      redirect    = 1'b1;
      redirect_pc = force_pc;
      force_redir = 1'b0;
    end else if (int'($urandom_range(0, 99)) < redir_pct) begin
      redirect = 1'b1;
      case ($urandom_range(0, 3))
        0:       redirect_pc = 32'hFFFF_FFF8;
        1:       redirect_pc = 32'h0000_0102;
        default: redirect_pc = {20'h0, $urandom_range(0, 1023) << 2} & 32'h0000_0FFC;
      endcase
    end else begin
      redirect_pc = $urandom;
    end

    // Model update
    accepted = mem_req && mem_ack;
    if (!redirect && model_q.size() != 0 && inst_ready) begin
      $display("pop pc=%08h inst=%08h", model_q[0].pc, model_q[0].inst);
      void'(model_q.pop_front());
    end
    if (accepted) begin
      mem_busy = 1'b0;
      if (!stale && !redirect) begin
        e.pc   = mem_addr;
        e.inst = mem_rdata;
        model_q.push_back(e);
        exp_pc = exp_pc + 32'd4;
      end
      stale = 1'b0;
    end
    if (redirect) begin
      model_q.delete();
      exp_pc = redirect_pc;
      if (mem_req && !mem_ack)
        stale = 1'b1;
    end
    prev_hold = mem_req && !mem_ack;
    prev_addr = mem_addr;
  endtask

  initial begin
    lat_mode    = 0;
    ready_mode  = 0;
    redir_pct   = 0;
    force_redir = 1'b0;
    force_pc    = '0;
    model_reset();
    do_reset();

    // Zero-wait, always ready: one instruction per cycle.
    for (int i = 0; i < 20; i++) step();

    // Decode stalled: exactly DEPTH entries accepted, then fetch stops.
    ready_mode = 1;
    for (int i = 0; i < 10; i++) step();
    check_val("full_entries", model_q.size(), DEPTH);
    check_val("full_no_req", mem_req, 1'b0);
    ready_mode = 0;
    for (int i = 0; i < 10; i++) step();

    // 3-cycle memory.
    lat_mode = 1;
    for (int i = 0; i < 24; i++) step();

    // Redirect near the top of the address space, zero-wait: PC wraps.
    lat_mode    = 0;
    force_redir = 1'b1;
    force_pc    = 32'hFFFF_FFFC;
    for (int i = 0; i < 10; i++) step();

    // Redirects against a slow memory: outstanding requests get dropped.
    lat_mode  = 1;
    redir_pct = 20;
    for (int i = 0; i < 60; i++) step();

    // Fully random traffic, with a reset in the middle.
    lat_mode   = 2;
    ready_mode = 2;
    redir_pct  = 6;
    for (int i = 0; i < 1500; i++) step();
    do_reset();
    for (int i = 0; i < 1500; i++) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/instr_fetch_queue.md
# instr_fetch_queue

Decoupled instruction fetch stage sitting directly upstream of the decode/execute datapath. Generates sequential fetch addresses, issues one request at a time to a variable-latency instruction memory over a req/ack handshake, and buffers returned instructions with their PCs in a DEPTH-entry FIFO. Decode consumes the head through a valid/ready handshake. A redirect from branch/jump resolution flushes the buffer, discards any in-flight response and restarts fetch at the new target.

## Interface
- ADDR_WIDTH, 32, width of PCs and memory addresses
- INST_WIDTH, 32, instruction width
- DEPTH, 4, FIFO entries; power of two, at least 2
- RESET_PC, 0, first fetch address after reset
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  asynchronous, active-low reset (rst=0 resets)
- mem_req  out  1  fetch request to instruction memory
- mem_addr  out  ADDR_WIDTH  fetch address; stable while mem_req=1
- mem_ack  in  1  memory accepts request and returns data this cycle
- mem_rdata  in  INST_WIDTH  instruction word, valid when mem_ack=1
- redirect  in  1  one-cycle pulse: flush and restart at redirect_pc
- redirect_pc  in  ADDR_WIDTH  new fetch address, sampled when redirect=1
- inst_valid  out  1  FIFO head valid
- inst  out  INST_WIDTH  head instruction
- inst_pc  out  ADDR_WIDTH  PC of head instruction
- inst_ready  in  1  decode consumes head when inst_valid & inst_ready

## Operation
- State: fetch_pc, FIFO (pc+inst per entry, rd/wr pointers, count), inflight flag, drop flag.
- Request issue: mem_req is a register. Raised next cycle when inflight=0, (count + pops-free room) allows: count + 1 <= DEPTH counting the in-flight slot, i.e. request only if count + inflight < DEPTH. mem_addr = fetch_pc.
- Handshake: once mem_req=1, mem_req and mem_addr hold until mem_ack=1 is sampled. mem_ack with mem_req=0 is ignored. On ack: mem_req drops or re-issues next cycle per the issue rule; fetch_pc += 4 (modulo 2^ADDR_WIDTH, wraps silently).
- Push: on ack with drop=0, {mem_addr, mem_rdata} written at wr pointer. Reservation rule guarantees no overflow.
- Pop: inst_valid & inst_ready advances rd pointer. Push and pop in same cycle: count unchanged, legal at full and at count=1.
- Redirect (highest priority): FIFO emptied (count=0, pointers reset), fetch_pc <= redirect_pc, concurrent pop ignored, concurrent push discarded. If a request is outstanding and not acked this cycle, mem_req/mem_addr keep holding the old request (handshake is never abandoned), drop=1; its data is discarded on ack, then fetch resumes at redirect_pc. Redirect in same cycle as ack: data discarded, no drop needed.
- Redirect while drop=1: fetch_pc updated again, drop stays 1.
- Misaligned redirect_pc passed through unchanged; no alignment checking.

## Timing
- Reset values: mem_req=0, mem_addr=RESET_PC, inst_valid=0, inst=0, inst_pc=0, fetch_pc=RESET_PC, count=0, inflight=0, drop=0.
- First mem_req=1 one cycle after rst deasserts.
- Zero-wait memory (ack same cycle as req): one instruction per cycle sustained; mem_req stays high continuously while room exists.
- Ack-to-inst_valid latency: 1 cycle (registered FIFO, no bypass).
- Redirect to new-target mem_req: 1 cycle if idle or acked same cycle; otherwise 1 cycle after the pending ack.
- inst_valid falls the cycle after redirect; inst/inst_pc are don't-care while inst_valid=0.
- Reset asserted mid-transaction: all state cleared immediately; memory side must treat the dropped mem_req as cancelled.

## Test plan
- Reset, zero-wait memory returning mem_rdata=addr, inst_ready=1 -> mem_addr 0,4,8,...; inst_pc/inst 0,4,8 each cycle from cycle 2.
- inst_ready=0, DEPTH=4 -> exactly 4 acks then mem_req=0; raise inst_ready -> entries 0,4,8,12 in order, fetch resumes at 16.
- Memory with 3-cycle ack latency -> mem_req/mem_addr stable 3 cycles per fetch, one entry per ack.
- Redirect to 0x100 while request to 0x8 outstanding (ack 2 cycles later) -> 0x8 data never appears; next mem_addr 0x100, first inst_pc 0x100.
- Redirect coinciding with ack and pop at full -> FIFO empty next cycle, ack data dropped, next mem_addr = redirect_pc.
- Redirect to 0xFFFFFFFC, zero-wait -> inst_pc 0xFFFFFFFC then 0x00000000.
